// File: rtl/vcm_focus_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// vcm_focus_sweep_ctrl
//
// Frame-synchronous auto-focus scheduler. It steps the VCM lens through a
// coarse sweep covering the whole range. It then runs a fine sweep of
// +/-COARSE_STEP around the best coarse position. Finally it parks the lens at
// the best position seen in either sweep.
//
// For each position the block does the following:
//   1. It issues one VCM write over a valid/ready handshake.
//   2. It ignores SETTLE_FRAMES frame boundaries while the lens settles.
//   3. It waits for one more frame boundary.
//   4. It samples the sharpness sum of the frame that just closed.
//
// Optional feature (compile-time macro VCM_EARLY_STOP_EN):
//   The coarse sweep ends early once two consecutive coarse samples fall
//   below half of the current peak, provided the peak is non-zero. Without
//   the macro the coarse sweep always covers the full range.
//
// Ports:
//   VIDEO_CLK  in   pixel clock, all logic on the rising edge
//   RESET      in   synchronous active-high reset
//   START      in   one-cycle search request, ignored while BUSY
//   VS         in   raw vertical sync, rising edge = frame boundary
//   SUM_IN     in   sharpness of the frame just closed
//   WR_READY   in   VCM writer accepts the current word
//   WR_VALID   out  VCM write request
//   VCM_DATA   out  {2'b00, VCM_STEP, 4'b1111}
//   VCM_STEP   out  lens position currently commanded
//   BUSY       out  high from START acceptance until the park write completes
//   DONE       out  high in the cycle the park write is accepted
//   PEAK_SUM   out  best sharpness found
//   PEAK_STEP  out  position of PEAK_SUM
//   STATE      out  FSM state code (debug)
// -----------------------------------------------------------------------------
module vcm_focus_sweep_ctrl #(
  parameter int STEP_W        = 10,
  parameter int SUM_W         = 32,
  parameter int COARSE_STEP   = 64,
  parameter int FINE_STEP     = 8,
  parameter int SETTLE_FRAMES = 1
) (
  input  logic              VIDEO_CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              VS,
  input  logic [SUM_W-1:0]  SUM_IN,
  input  logic              WR_READY,
  output logic              WR_VALID,
  output logic [15:0]       VCM_DATA,
  output logic [STEP_W-1:0] VCM_STEP,
  output logic              BUSY,
  output logic              DONE,
  output logic [SUM_W-1:0]  PEAK_SUM,
  output logic [STEP_W-1:0] PEAK_STEP,
  output logic [2:0]        STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_SAMPLE  = 3'd4,
    S_EVAL    = 3'd5,
    S_PARK    = 3'd6
  } state_e;

  typedef enum logic {
    PH_COARSE = 1'b0,
    PH_FINE   = 1'b1
  } phase_e;

  localparam logic [STEP_W:0]   CSTEP_X     = (STEP_W+1)'(COARSE_STEP);
  localparam logic [STEP_W:0]   FSTEP_X     = (STEP_W+1)'(FINE_STEP);
  localparam logic [STEP_W-1:0] CSTEP       = STEP_W'(COARSE_STEP);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_FRAMES - 1);

  // Lower edge of the fine window, floored at position 0.
  function automatic logic [STEP_W-1:0] fine_lo(input logic [STEP_W-1:0] p);
    return (p >= CSTEP) ? (p - CSTEP) : '0;
  endfunction

  // Upper edge of the fine window, saturated at the top position.
  function automatic logic [STEP_W-1:0] fine_hi(input logic [STEP_W-1:0] p);
    logic [STEP_W:0] s;
    s = {1'b0, p} + CSTEP_X;
    return s[STEP_W] ? '1 : s[STEP_W-1:0];
  endfunction

  function automatic logic [15:0] mk_data(input logic [STEP_W-1:0] p);
    return 16'({p, 4'b1111});
  endfunction

  state_e              state_q;
  phase_e              phase_q;
  logic                vs_d_q;
  logic [3:0]          settle_cnt_q;
  logic [SUM_W-1:0]    sample_q;
  logic [SUM_W-1:0]    peak_sum_q;
  logic [STEP_W-1:0]   peak_step_q;
  logic [STEP_W-1:0]   vcm_step_q;
  logic [15:0]         vcm_data_q;
  logic [STEP_W-1:0]   fine_hi_q;
  logic                wr_valid_q;
  logic                busy_q;

  logic                vs_rise;
  logic                upd_d;
  logic [SUM_W-1:0]    peak_sum_d;
  logic [STEP_W-1:0]   peak_step_d;
  logic [STEP_W:0]     coarse_next_d;
  logic [STEP_W:0]     fine_next_d;
  logic                coarse_end_d;
  logic                fine_end_d;
  logic                early_d;

  assign vs_rise = VS & ~vs_d_q;

  // EVAL decisions. The peak update is folded in before the fine window is
  // derived, so a peak found at the last coarse sample centres the window.
  assign upd_d         = sample_q > peak_sum_q;
  assign peak_sum_d    = upd_d ? sample_q   : peak_sum_q;
  assign peak_step_d   = upd_d ? vcm_step_q : peak_step_q;
  assign coarse_next_d = {1'b0, vcm_step_q} + CSTEP_X;
  assign fine_next_d   = {1'b0, vcm_step_q} + FSTEP_X;
  // The top position is all ones, so "next > max" is simply the carry bit.
  assign coarse_end_d  = coarse_next_d[STEP_W] | early_d;
  assign fine_end_d    = fine_next_d > {1'b0, fine_hi_q};

`ifdef VCM_EARLY_STOP_EN
  logic [1:0] low_cnt_q;
  logic [1:0] low_cnt_d;

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

  // A "low" sample is judged against the peak as it stood before this sample.
  assign low_cnt_d = (sample_q < (peak_sum_q >> 1)) ? sat_inc2(low_cnt_q) : 2'd0;
  assign early_d   = (peak_sum_d != '0) && (low_cnt_d == 2'd2);
`else
  assign early_d   = 1'b0;
`endif

  always_ff @(posedge VIDEO_CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_COARSE;
      vs_d_q       <= 1'b0;
      settle_cnt_q <= '0;
      sample_q     <= '0;
      peak_sum_q   <= '0;
      peak_step_q  <= '0;
      vcm_step_q   <= '0;
      vcm_data_q   <= '0;
      fine_hi_q    <= '0;
      wr_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
`ifdef VCM_EARLY_STOP_EN
      low_cnt_q    <= '0;
`endif
    end else begin
      vs_d_q <= VS;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_q     <= S_WRITE;
            phase_q     <= PH_COARSE;
            vcm_step_q  <= '0;
            vcm_data_q  <= mk_data('0);
            peak_sum_q  <= '0;
            peak_step_q <= '0;
            wr_valid_q  <= 1'b1;
            busy_q      <= 1'b1;
`ifdef VCM_EARLY_STOP_EN
            low_cnt_q   <= '0;
`endif
          end
        end

        S_WRITE: begin
          // VCM_DATA is only reloaded on entry to WRITE/PARK, so it stays
          // stable for the whole handshake.
          if (WR_READY) begin
            state_q      <= S_SETTLE;
            wr_valid_q   <= 1'b0;
            settle_cnt_q <= '0;
          end
        end

        S_SETTLE: begin
          if (vs_rise) begin
            if (settle_cnt_q == SETTLE_LAST) begin
              state_q <= S_MEASURE;
            end else begin
              settle_cnt_q <= settle_cnt_q + 4'd1;
            end
          end
        end

        S_MEASURE: begin
          if (vs_rise) begin
            state_q <= S_SAMPLE;
          end
        end

        S_SAMPLE: begin
          sample_q <= SUM_IN;
          state_q  <= S_EVAL;
        end

        S_EVAL: begin
          peak_sum_q  <= peak_sum_d;
          peak_step_q <= peak_step_d;
          if (phase_q == PH_COARSE) begin
`ifdef VCM_EARLY_STOP_EN
            low_cnt_q <= low_cnt_d;
`endif
            state_q    <= S_WRITE;
            wr_valid_q <= 1'b1;
            if (coarse_end_d) begin
              phase_q    <= PH_FINE;
              fine_hi_q  <= fine_hi(peak_step_d);
              vcm_step_q <= fine_lo(peak_step_d);
              vcm_data_q <= mk_data(fine_lo(peak_step_d));
            end else begin
              vcm_step_q <= coarse_next_d[STEP_W-1:0];
              vcm_data_q <= mk_data(coarse_next_d[STEP_W-1:0]);
            end
          end else if (fine_end_d) begin
            state_q    <= S_PARK;
            wr_valid_q <= 1'b1;
            vcm_step_q <= peak_step_d;
            vcm_data_q <= mk_data(peak_step_d);
          end else begin
            state_q    <= S_WRITE;
            wr_valid_q <= 1'b1;
            vcm_step_q <= fine_next_d[STEP_W-1:0];
            vcm_data_q <= mk_data(fine_next_d[STEP_W-1:0]);
          end
        end

        S_PARK: begin
          if (WR_READY) begin
            state_q    <= S_IDLE;
            wr_valid_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign WR_VALID  = wr_valid_q;
  assign VCM_DATA  = vcm_data_q;
  assign VCM_STEP  = vcm_step_q;
  assign BUSY      = busy_q;
  // DONE marks the accept cycle itself, so it follows WR_READY directly.
  assign DONE      = (state_q == S_PARK) & WR_READY & ~RESET;
  assign PEAK_SUM  = peak_sum_q;
  assign PEAK_STEP = peak_step_q;
  assign STATE     = state_q;

endmodule

// File: doc/vcm_focus_sweep_ctrl.md
Name: vcm_focus_sweep_ctrl

Overview:
- Frame-synchronous scheduler for the auto-focus loop: sequences VCM lens positions through a coarse sweep, then a fine sweep around the best coarse position, and parks the lens at the global sharpness peak.
- Per position: issues one VCM write over a valid/ready handshake to the I2C VCM writer, waits settle frames, then samples the per-frame sharpness count (SUM) from the sharpness datapath.
- Sits between the sharpness counter and the VCM I2C writer; replaces free-running stepping with a bounded, deterministic search.

Parameters:
- STEP_W, 10, VCM position width (0..2^STEP_W-1).
- SUM_W, 32, sharpness sum width.
- COARSE_STEP, 64, coarse increment; also the fine half-span.
- FINE_STEP, 8, fine increment.
- SETTLE_FRAMES, 1, VS rising edges ignored after each accepted write (1..15).

Ports:
- VIDEO_CLK  in  1  pixel clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request to begin a search; ignored while BUSY.
- VS  in  1  raw vertical sync; rising edge = frame boundary.
- SUM_IN  in  SUM_W  sharpness of the frame just closed, stable from the cycle after VS rises.
- WR_READY  in  1  VCM writer accepts the current word.
- WR_VALID  out  1  VCM write request.
- VCM_DATA  out  16  {2'b00, VCM_STEP, 4'b1111}.
- VCM_STEP  out  STEP_W  position currently commanded.
- BUSY  out  1  high from START acceptance until DONE.
- DONE  out  1  one-cycle pulse when the final park write is accepted.
- PEAK_SUM  out  SUM_W  best sharpness found.
- PEAK_STEP  out  STEP_W  position of PEAK_SUM.
- STATE  out  3  FSM state code for debug.

Behaviour:
- Reset: all outputs 0; state IDLE; phase COARSE; internal VS register 0.
- vs_rise = VS & ~VS_d (one register).
- States and codes: IDLE 0, WRITE 1, SETTLE 2, MEASURE 3, SAMPLE 4, EVAL 5, PARK 6.
- IDLE: on START go to WRITE with VCM_STEP=0, phase=COARSE, PEAK_SUM=0, PEAK_STEP=0, BUSY=1.
- WRITE:
  - WR_VALID=1, VCM_DATA held stable until WR_VALID&WR_READY.
  - On the accept cycle go to SETTLE and clear the settle counter. Accept may occur in the first WRITE cycle.
- SETTLE: count vs_rise; on the SETTLE_FRAMES-th edge go to MEASURE. A vs_rise in the accept cycle is not counted.
- MEASURE: on the next vs_rise go to SAMPLE.
- SAMPLE: one cycle; capture SUM_IN, then go to EVAL.
- EVAL (one cycle):
  - Peak update: if sample > PEAK_SUM (strict; ties keep the earlier position), set PEAK_SUM=sample and PEAK_STEP=VCM_STEP.
  - Next position:
    - COARSE: next = VCM_STEP+COARSE_STEP, computed at STEP_W+1 bits. If next <= max, go to WRITE at next. Otherwise switch to FINE and go to WRITE at lo = (PEAK_STEP>=COARSE_STEP) ? PEAK_STEP-COARSE_STEP : 0. The peak update takes effect before lo is computed.
    - FINE: hi = min(PEAK_STEP_at_fine_entry+COARSE_STEP, max), latched on FINE entry. next = VCM_STEP+FINE_STEP; if next <= hi go to WRITE at next, else go to PARK.
  - Fine positions may repeat coarse positions; they are re-measured normally.
- PARK:
  - WR_VALID=1 with VCM_STEP=PEAK_STEP.
  - On accept: DONE=1 for that cycle, BUSY=0 next cycle, go to IDLE.
  - VCM_STEP, PEAK_SUM and PEAK_STEP hold until the next START.
- START while BUSY: ignored. START coincident with RESET: RESET wins.
- RESET mid-search, including mid-handshake: WR_VALID drops the next cycle and everything returns to reset values. The writer must tolerate an abandoned request.
- PEAK_SUM=0 forever (all-black scene): park at position 0.
- Latency per position: accept → SETTLE_FRAMES+1 vs_rise edges → +2 cycles to the next WR_VALID.

Optional Feature:
- Macro: VCM_EARLY_STOP_EN.
- When defined:
  - COARSE phase tracks a 2-bit counter of consecutive samples with sample < PEAK_SUM/2 (right shift by 1).
  - The counter clears on any other sample.
  - Once PEAK_SUM>0 and the counter reaches 2, the coarse sweep ends early (same transition as overflow).
  - FINE phase is unaffected.
- When undefined: the coarse sweep always covers 0..max, and the counter logic is absent.

Test Plan:
- Defaults, SETTLE_FRAMES=1, WR_READY=1, SUM_IN = 100000-|step-520|*100:
  - Coarse writes 0,64,…,960 (16 writes).
  - Fine writes 448,456,…,576.
  - PARK writes 520; PEAK_SUM=100000; DONE pulses once.
  - Each VCM_DATA = {2'b00,step,4'b1111}.
- Handshake stall: WR_READY low 5 cycles at step 64 → WR_VALID held and VCM_DATA=0x040F stable for 5 cycles; settle counting starts only after accept.
- Timing: SETTLE_FRAMES=2 → exactly 3 vs_rise per position between accept and the EVAL update. A vs_rise in the accept cycle is ignored.
- Boundary and ties:
  - Peak at step 0 → fine range 0..64.
  - Peak at 960 → fine hi clamps to 1023; last fine write 1016.
  - Equal SUM at 128 and 192 → PEAK_STEP=128.
- Robustness:
  - RESET asserted in SETTLE and again during PARK with WR_READY=0 → next cycle all outputs 0, STATE=0.
  - START pulsed while BUSY → no effect.
- VCM_EARLY_STOP_EN, SUM peaking at 128 then falling below half → coarse stops after 256; fine begins at 64.
